// File: rtl/ecc_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ecc_job_sequencer
//  Purpose  : Queues ECC jobs (encode / decode / full round trip with
//             injected noise), drives one external encoder and one external
//             decoder through each job in order, guards every engine wait
//             with a watchdog, and returns one result per job over a
//             valid/ready handshake. Keeps saturating job and
//             uncorrectable-error counters.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset                 rising-edge clock, async active-high reset
//    cmd_valid / cmd_ready      command handshake (ready = FIFO has room)
//    cmd_mode                   00 encode, 01 decode, 10 full, 11 illegal
//    cmd_data/width/noise       payload, codeword width, full-mode noise
//    eng_data, eng_width        operands presented to the active engine
//    enc_en / dec_en            engine enables (never both high)
//    enc_done / dec_done        engine completion pulses
//    enc_result / dec_result    engine outputs, dec_num_err decoder status
//    res_valid / res_ready      result handshake
//    res_data, res_num_errors   job result
//    res_status                 00 ok, 01 timeout, 10 illegal
//    stat_jobs, stat_uncorr     saturating accepted-result counters
//    busy                       FSM active or jobs still queued
// ============================================================================
module ecc_job_sequencer #(
    parameter int AMBA_WORD   = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_mode,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [AMBA_WORD-1:0]  cmd_width,
    input  logic [DATA_WIDTH-1:0] cmd_noise,
    output logic [DATA_WIDTH-1:0] eng_data,
    output logic [AMBA_WORD-1:0]  eng_width,
    output logic                  enc_en,
    output logic                  dec_en,
    input  logic                  enc_done,
    input  logic                  dec_done,
    input  logic [DATA_WIDTH-1:0] enc_result,
    input  logic [DATA_WIDTH-1:0] dec_result,
    input  logic [1:0]            dec_num_err,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [1:0]            res_num_errors,
    output logic [1:0]            res_status,
    output logic [15:0]           stat_jobs,
    output logic [15:0]           stat_uncorr,
    output logic                  busy
);

    localparam int c_PTR_W = $clog2(QUEUE_DEPTH);
    localparam int c_WD_W  = $clog2(TIMEOUT);
    localparam logic [c_PTR_W:0]  c_DEPTH   = (c_PTR_W+1)'(QUEUE_DEPTH);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_ENC      = 3'd1;
    localparam logic [2:0] c_ST_DEC      = 3'd2;
    localparam logic [2:0] c_ST_FULL_ENC = 3'd3;
    localparam logic [2:0] c_ST_FULL_DEC = 3'd4;
    localparam logic [2:0] c_ST_RESP     = 3'd5;

    localparam logic [1:0] c_STS_OK      = 2'b00;
    localparam logic [1:0] c_STS_TIMEOUT = 2'b01;
    localparam logic [1:0] c_STS_ILLEGAL = 2'b10;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [1:0]            r_fifo_mode  [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data  [QUEUE_DEPTH];
    logic [AMBA_WORD-1:0]  r_fifo_width [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_noise [QUEUE_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_count;

    logic                  w_push;
    logic                  w_pop;

    // A full FIFO still takes a command when the head leaves in the same cycle.
    assign cmd_ready = (r_count != c_DEPTH) || w_pop;
    assign w_push    = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mode[r_wr_ptr]  <= cmd_mode;
            r_fifo_data[r_wr_ptr]  <= cmd_data;
            r_fifo_width[r_wr_ptr] <= cmd_width;
            r_fifo_noise[r_wr_ptr] <= cmd_noise;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Job sequencing FSM
    // ------------------------------------------------------------------
    logic [2:0]            r_state;
    logic [2:0]            w_next_state;
    logic [DATA_WIDTH-1:0] r_job_data;
    logic [AMBA_WORD-1:0]  r_job_width;
    logic [DATA_WIDTH-1:0] r_job_noise;
    logic [DATA_WIDTH-1:0] r_mid;       // noisy codeword between full-mode phases
    logic [c_WD_W-1:0]     r_wdog;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic [1:0]            r_res_nerr;
    logic [1:0]            r_res_status;
    logic [15:0]           r_stat_jobs;
    logic [15:0]           r_stat_uncorr;

    logic                  w_wd_expired;
    logic                  w_load_res;
    logic                  w_load_mid;
    logic [DATA_WIDTH-1:0] w_res_data;
    logic [1:0]            w_res_nerr;
    logic [1:0]            w_res_status;
    logic                  w_accept;

    assign w_wd_expired = (r_wdog == c_WD_LAST);
    assign w_accept     = (r_state == c_ST_RESP) && res_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Done pulses are only looked at in the state waiting for them, and
    // they take priority over an expiring watchdog.
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_load_res   = 1'b0;
        w_load_mid   = 1'b0;
        w_res_data   = '0;
        w_res_nerr   = 2'b00;
        w_res_status = c_STS_OK;
        enc_en       = 1'b0;
        dec_en       = 1'b0;
        eng_data     = '0;
        eng_width    = '0;
        res_valid    = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop = 1'b1;
                    case (r_fifo_mode[r_rd_ptr])
                        2'b00:   w_next_state = c_ST_ENC;
                        2'b01:   w_next_state = c_ST_DEC;
                        2'b10:   w_next_state = c_ST_FULL_ENC;
                        default: begin
                            w_next_state = c_ST_RESP;
                            w_load_res   = 1'b1;
                            w_res_status = c_STS_ILLEGAL;
                        end
                    endcase
                end
            end
            c_ST_ENC, c_ST_FULL_ENC: begin
                enc_en    = 1'b1;
                eng_data  = r_job_data;
                eng_width = r_job_width;
                if (enc_done) begin
                    if (r_state == c_ST_ENC) begin
                        w_next_state = c_ST_RESP;
                        w_load_res   = 1'b1;
                        w_res_data   = enc_result;
                    end else begin
                        w_next_state = c_ST_FULL_DEC;
                        w_load_mid   = 1'b1;
                    end
                end else if (w_wd_expired) begin
                    w_next_state = c_ST_RESP;
                    w_load_res   = 1'b1;
                    w_res_status = c_STS_TIMEOUT;
                end
            end
            c_ST_DEC, c_ST_FULL_DEC: begin
                dec_en    = 1'b1;
                eng_data  = (r_state == c_ST_DEC) ? r_job_data : r_mid;
                eng_width = r_job_width;
                if (dec_done) begin
                    w_next_state = c_ST_RESP;
                    w_load_res   = 1'b1;
                    w_res_data   = dec_result;
                    w_res_nerr   = dec_num_err;
                end else if (w_wd_expired) begin
                    w_next_state = c_ST_RESP;
                    w_load_res   = 1'b1;
                    w_res_status = c_STS_TIMEOUT;
                end
            end
            c_ST_RESP: begin
                res_valid = 1'b1;
                if (res_ready) w_next_state = c_ST_IDLE;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Job registers, watchdog, result and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_job_data    <= '0;
            r_job_width   <= '0;
            r_job_noise   <= '0;
            r_mid         <= '0;
            r_wdog        <= '0;
            r_res_data    <= '0;
            r_res_nerr    <= 2'b00;
            r_res_status  <= c_STS_OK;
            r_stat_jobs   <= '0;
            r_stat_uncorr <= '0;
        end else begin
            if (w_pop) begin
                r_job_data  <= r_fifo_data[r_rd_ptr];
                r_job_width <= r_fifo_width[r_rd_ptr];
                r_job_noise <= r_fifo_noise[r_rd_ptr];
            end
            if (w_load_mid) r_mid <= enc_result ^ r_job_noise;
            if (w_load_res) begin
                r_res_data   <= w_res_data;
                r_res_nerr   <= w_res_nerr;
                r_res_status <= w_res_status;
            end
            // Restart on every state change so each engine phase gets a full budget.
            if (w_next_state != r_state)
                r_wdog <= '0;
            else if (r_state == c_ST_ENC || r_state == c_ST_DEC ||
                     r_state == c_ST_FULL_ENC || r_state == c_ST_FULL_DEC)
                r_wdog <= r_wdog + 1'b1;
            if (w_accept) begin
                if (r_stat_jobs != 16'hFFFF) r_stat_jobs <= r_stat_jobs + 16'd1;
                if (r_res_nerr == 2'd2 && r_stat_uncorr != 16'hFFFF)
                    r_stat_uncorr <= r_stat_uncorr + 16'd1;
            end
        end
    end

    assign res_data       = r_res_data;
    assign res_num_errors = r_res_nerr;
    assign res_status     = r_res_status;
    assign stat_jobs      = r_stat_jobs;
    assign stat_uncorr    = r_stat_uncorr;
    assign busy           = (r_state != c_ST_IDLE) || (r_count != '0);

endmodule
`default_nettype wire
